btn_debouncer: RTL and testbench
================================

BTN_DEBOUNCER -- requirements
Module: btn_debouncer

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 1000000, stable-input cycles required before accepting a level change (10 ms at 100 MHz); legal range >= 2.
REQ-002 Parameter: SYNC_STAGES, default 2, flip-flop depth of the input synchronizer; legal range >= 2.
REQ-003 Parameter: REPEAT_CYCLES, default 50000000, auto-repeat period while held; used only with BTN_REPEAT_EN; legal range >= 2.
REQ-004 clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 reset  input  1  reset, synchronous and active-high.
REQ-006 btn  input  1  raw asynchronous push-button (btnC), may bounce.
REQ-007 btn_level  output  1  debounced button level.
REQ-008 btn_rise  output  1  one-clk pulse on accepted press; downstream flip-flop stage uses it as clock enable.
REQ-009 btn_fall  output  1  one-clk pulse on accepted release.
REQ-010 btn_repeat  output  1  one-clk auto-repeat pulse while held (tied 0 without BTN_REPEAT_EN).

Function
REQ-011 btn SHALL pass through a SYNC_STAGES-deep flop chain; the FSM SHALL observe only the last stage (sync).
REQ-012 FSM states SHALL be STABLE_LOW, WAIT_HIGH, STABLE_HIGH, WAIT_LOW.
REQ-013 STABLE_LOW with sync=1 -> WAIT_HIGH, counter loaded with 1; else remain.
REQ-014 WAIT_HIGH with sync=0 -> STABLE_LOW (bounce rejected, no pulse); sync=1 and counter<DEBOUNCE_CYCLES -> counter+1; sync=1 and counter=DEBOUNCE_CYCLES -> STABLE_HIGH.
REQ-015 STABLE_HIGH/WAIT_LOW SHALL mirror REQ-013/014 with sync polarity inverted.
REQ-016 btn_level SHALL be 1 exactly in STABLE_HIGH and WAIT_LOW.
REQ-017 btn_rise SHALL be registered, high for exactly the one cycle following the WAIT_HIGH->STABLE_HIGH transition edge; btn_fall likewise for WAIT_LOW->STABLE_LOW.
REQ-018 Latency: raw btn step held stable -> btn_level/btn_rise change exactly SYNC_STAGES+DEBOUNCE_CYCLES+1 clk edges after the first edge sampling the new value.
REQ-019 Any glitch shorter than DEBOUNCE_CYCLES cycles (after synchronization) SHALL produce no output change.
REQ-020 Counter width SHALL be clog2(DEBOUNCE_CYCLES+1); it SHALL never wrap; it is don't-care in STABLE states.
REQ-021 btn_rise, btn_fall, btn_repeat SHALL be mutually exclusive in any cycle.

Reset
REQ-022 reset=1 at a clk edge SHALL force state STABLE_LOW, counters 0, sync chain all 0, all outputs 0 on the following cycle, overriding any in-progress WAIT state.
REQ-023 Button held through reset release SHALL yield a normal press: btn_rise after the full REQ-018 latency, measured from the first non-reset edge.

Configuration
REQ-024 Macro BTN_REPEAT_EN defined: in STABLE_HIGH a repeat counter SHALL emit btn_repeat every REPEAT_CYCLES cycles, first pulse REPEAT_CYCLES cycles after btn_rise; counter cleared on leaving STABLE_HIGH; no repeat pulses in WAIT_LOW.
REQ-025 Macro undefined: repeat counter SHALL not be synthesized; btn_repeat constant 0; all other behaviour identical.

Structure
REQ-026 Shared package btn_debounce_pkg SHALL hold the FSM state typedef (2-bit enum) and default constants for DEBOUNCE_CYCLES, SYNC_STAGES, REPEAT_CYCLES.
REQ-027 Synchronizer SHALL be a separate sub-module sync_chain (parameter STAGES, ports clk, reset, d, q), reusable for sw inputs.

Verification (DEBOUNCE_CYCLES=4, SYNC_STAGES=2, REPEAT_CYCLES=8)
REQ-028 Clean press: btn 0->1 held 20 cycles -> btn_level=1 and single btn_rise pulse 7 edges after first high sample; no btn_fall.
REQ-029 Bounce: btn 1,0,1,0 each 2 cycles then 1 held -> no pulse during bounce; one btn_rise 7 edges after final stable rise.
REQ-030 Release: from STABLE_HIGH, btn 1->0 held -> btn_level=0 and one btn_fall 7 edges later.
REQ-031 Reset mid-WAIT: reset at 3rd WAIT_HIGH cycle with btn held -> outputs 0 next cycle; btn_rise 7 edges after reset deasserts.
REQ-032 Repeat (BTN_REPEAT_EN): hold 40 cycles after btn_rise -> btn_repeat pulses at +8, +16, +24, +32, +40; undefined build -> btn_repeat stays 0.
REQ-033 Short glitch: single-cycle btn=1 pulse -> btn_level, btn_rise, btn_fall remain 0 throughout.

Source files
------------

// File: rtl/btn_debounce_pkg.sv
// Shared types and default constants for the push-button debouncer.
// The FSM state type lives here so that the top level and any future
// debouncer variants agree on the encoding.
package btn_debounce_pkg;

  // 10 ms of stable input at a 100 MHz system clock
  localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;
  // Two flops are the usual minimum for metastability settling
  localparam int DEFAULT_SYNC_STAGES     = 2;
  // Half a second between auto-repeat pulses at 100 MHz
  localparam int DEFAULT_REPEAT_CYCLES   = 50000000;

  // Two stable states, each paired with a qualifying state for the opposite level
  typedef enum logic [1:0] {
    STABLE_LOW  = 2'b00,
    WAIT_HIGH   = 2'b01,
    STABLE_HIGH = 2'b10,
    WAIT_LOW    = 2'b11
  } btn_state_e;

  // The debounced level is high while accepted-high, including while
  // a release is still being qualified
  function automatic logic level_of(input btn_state_e s);
    return (s == STABLE_HIGH) || (s == WAIT_LOW);
  endfunction

endpackage

// File: rtl/btn_debouncer_sync_chain.sv
// Generic multi-flop synchronizer for asynchronous single-bit inputs
// (push-buttons, slide switches). Only the last stage should be used
// by downstream logic.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] stage_q;
  logic [STAGES-1:0] stage_d;

  // Shift the raw input in at the bottom; the top bit is the settled value
  always_comb begin
    stage_d = {stage_q[STAGES-2:0], d};
  end

  // Chain registers, cleared so a held button looks like a fresh press after reset
  always_ff @(posedge clk) begin
    if (reset) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/btn_debouncer.sv
// Push-button debouncer: synchronizer, four-state qualify FSM and
// registered edge pulses. Optional auto-repeat while held is enabled
// by defining the macro BTN_REPEAT_EN; without it btn_repeat is tied 0
// and no repeat counter exists.
module btn_debouncer
  import btn_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic btn_level,
  output logic btn_rise,
  output logic btn_fall,
  output logic btn_repeat
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Reject configurations the counters cannot represent sensibly
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("btn_debouncer: DEBOUNCE_CYCLES must be >= 2");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("btn_debouncer: SYNC_STAGES must be >= 2");
  end
  if (REPEAT_CYCLES < 2) begin : g_bad_repeat
    $error("btn_debouncer: REPEAT_CYCLES must be >= 2");
  end

  logic       sync;
  btn_state_e state_q;
  btn_state_e state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic       rise_q;
  logic       rise_d;
  logic       fall_q;
  logic       fall_d;

  sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn),
    .q     (sync)
  );

  // Qualify level changes: a new level must persist for the full count
  // before it is accepted; any reversion during qualification drops back
  // silently. The counter saturates at CNT_MAX, so it never wraps.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      STABLE_LOW: begin
        if (sync) begin
          state_d = WAIT_HIGH;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_HIGH: begin
        if (!sync) begin
          state_d = STABLE_LOW;
        end else if (cnt_q < CNT_MAX) begin
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          state_d = STABLE_HIGH;
          rise_d  = 1'b1;
        end
      end
      STABLE_HIGH: begin
        if (!sync) begin
          state_d = WAIT_LOW;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_LOW: begin
        if (sync) begin
          state_d = STABLE_HIGH;
        end else if (cnt_q < CNT_MAX) begin
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          state_d = STABLE_LOW;
          fall_d  = 1'b1;
        end
      end
      default: begin
        state_d = STABLE_LOW;
      end
    endcase
  end

  // FSM, qualify counter and edge pulse registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= STABLE_LOW;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign btn_level = level_of(state_q);
  assign btn_rise  = rise_q;
  assign btn_fall  = fall_q;

`ifdef BTN_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CYCLES);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
  localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);

  logic [REP_W-1:0] rep_cnt_q;
  logic [REP_W-1:0] rep_cnt_d;
  logic             repeat_q;
  logic             repeat_d;

  // Count only while the button stays accepted-high; leaving STABLE_HIGH
  // (including into WAIT_LOW) clears the count, so no pulse can land in
  // WAIT_LOW or coincide with a rise/fall pulse
  always_comb begin
    rep_cnt_d = '0;
    repeat_d  = 1'b0;
    if ((state_q == STABLE_HIGH) && (state_d == STABLE_HIGH)) begin
      if (rep_cnt_q == REP_LAST) begin
        repeat_d = 1'b1;
      end else begin
        rep_cnt_d = rep_cnt_q + REP_ONE;
      end
    end
  end

  // Repeat counter and pulse register
  always_ff @(posedge clk) begin
    if (reset) begin
      rep_cnt_q <= '0;
      repeat_q  <= 1'b0;
    end else begin
      rep_cnt_q <= rep_cnt_d;
      repeat_q  <= repeat_d;
    end
  end

  assign btn_repeat = repeat_q;
`else
  assign btn_repeat = 1'b0;
`endif

endmodule

// File: tb/tb_btn_debouncer.sv
// Directed testbench for btn_debouncer with DEBOUNCE_CYCLES=4,
// SYNC_STAGES=2, REPEAT_CYCLES=8. Expected latencies are hand-derived:
// a stable step is accepted 7 edges after the first edge sampling it.
module tb_btn_debouncer;

`ifdef BTN_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic clk;
  logic reset;
  logic btn;
  logic btn_level;
  logic btn_rise;
  logic btn_fall;
  logic btn_repeat;

  int tests_run;
  int tests_failed;

  btn_debouncer #(
    .DEBOUNCE_CYCLES (4),
    .SYNC_STAGES     (2),
    .REPEAT_CYCLES   (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn        (btn),
    .btn_level  (btn_level),
    .btn_rise   (btn_rise),
    .btn_fall   (btn_fall),
    .btn_repeat (btn_repeat)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one clock and move just past the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    btn   = 1'b0;
    tick();
    tick();
    tests_run++;
    if (btn_level !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset level got %b exp 0", btn_level); end
    tests_run++;
    if (btn_rise !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset rise got %b exp 0", btn_rise); end
    tests_run++;
    if (btn_fall !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset fall got %b exp 0", btn_fall); end
    tests_run++;
    if (btn_repeat !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset repeat got %b exp 0", btn_repeat); end
    reset = 1'b0;
  endtask

  task automatic test_glitch();
    btn = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 1) btn = 1'b0;
      tests_run++;
      if (btn_level !== 1'b0) begin tests_failed++; $display("[TB] FAIL glitch level k=%0d got %b exp 0", k, btn_level); end
      tests_run++;
      if (btn_rise !== 1'b0) begin tests_failed++; $display("[TB] FAIL glitch rise k=%0d got %b exp 0", k, btn_rise); end
      tests_run++;
      if (btn_fall !== 1'b0) begin tests_failed++; $display("[TB] FAIL glitch fall k=%0d got %b exp 0", k, btn_fall); end
    end
  endtask

  task automatic test_clean_press();
    logic exp_level, exp_rise, exp_rep;
    btn = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      exp_level = (k >= 7);
      exp_rise  = (k == 7);
      exp_rep   = REP_EN && (k > 7) && (((k - 7) % 8) == 0);
      tests_run++;
      if (btn_level !== exp_level) begin tests_failed++; $display("[TB] FAIL press level k=%0d got %b exp %b", k, btn_level, exp_level); end
      tests_run++;
      if (btn_rise !== exp_rise) begin tests_failed++; $display("[TB] FAIL press rise k=%0d got %b exp %b", k, btn_rise, exp_rise); end
      tests_run++;
      if (btn_fall !== 1'b0) begin tests_failed++; $display("[TB] FAIL press fall k=%0d got %b exp 0", k, btn_fall); end
      tests_run++;
      if (btn_repeat !== exp_rep) begin tests_failed++; $display("[TB] FAIL press repeat k=%0d got %b exp %b", k, btn_repeat, exp_rep); end
    end
  endtask

  // Continues the hold from the clean press; rise was at k=7
  task automatic test_repeat();
    logic exp_rep;
    for (int k = 21; k <= 48; k++) begin
      tick();
      exp_rep = REP_EN && (((k - 7) % 8) == 0);
      tests_run++;
      if (btn_repeat !== exp_rep) begin tests_failed++; $display("[TB] FAIL repeat pulse k=%0d got %b exp %b", k, btn_repeat, exp_rep); end
      tests_run++;
      if (btn_level !== 1'b1) begin tests_failed++; $display("[TB] FAIL repeat level k=%0d got %b exp 1", k, btn_level); end
      tests_run++;
      if ((btn_rise | btn_fall) !== 1'b0) begin tests_failed++; $display("[TB] FAIL repeat edges k=%0d got rise=%b fall=%b exp 0", k, btn_rise, btn_fall); end
    end
  endtask

  task automatic test_release();
    logic exp_level, exp_fall;
    btn = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      exp_level = (k < 7);
      exp_fall  = (k == 7);
      tests_run++;
      if (btn_level !== exp_level) begin tests_failed++; $display("[TB] FAIL release level k=%0d got %b exp %b", k, btn_level, exp_level); end
      tests_run++;
      if (btn_fall !== exp_fall) begin tests_failed++; $display("[TB] FAIL release fall k=%0d got %b exp %b", k, btn_fall, exp_fall); end
      tests_run++;
      if (btn_rise !== 1'b0) begin tests_failed++; $display("[TB] FAIL release rise k=%0d got %b exp 0", k, btn_rise); end
      tests_run++;
      if (btn_repeat !== 1'b0) begin tests_failed++; $display("[TB] FAIL release repeat k=%0d got %b exp 0", k, btn_repeat); end
    end
  endtask

  // Pattern 1,1,0,0,1,1,0,0 then held 1; final stable rise sampled at k=9
  task automatic test_bounce();
    logic [7:0] pattern;
    logic exp_level, exp_rise;
    pattern = 8'b0011_0011;
    btn = pattern[0];
    for (int k = 1; k <= 20; k++) begin
      tick();
      btn = (k < 8) ? pattern[k] : 1'b1;
      exp_level = (k >= 15);
      exp_rise  = (k == 15);
      tests_run++;
      if (btn_level !== exp_level) begin tests_failed++; $display("[TB] FAIL bounce level k=%0d got %b exp %b", k, btn_level, exp_level); end
      tests_run++;
      if (btn_rise !== exp_rise) begin tests_failed++; $display("[TB] FAIL bounce rise k=%0d got %b exp %b", k, btn_rise, exp_rise); end
      tests_run++;
      if (btn_fall !== 1'b0) begin tests_failed++; $display("[TB] FAIL bounce fall k=%0d got %b exp 0", k, btn_fall); end
    end
  endtask

  // Reset from STABLE_HIGH, then reset again in the 3rd WAIT_HIGH cycle with btn held
  task automatic test_reset_mid_wait();
    logic exp_level, exp_rise;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests_run++;
    if (btn_level !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_high level got %b exp 0", btn_level); end
    tests_run++;
    if ((btn_rise | btn_fall | btn_repeat) !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_high pulses got r=%b f=%b p=%b exp 0", btn_rise, btn_fall, btn_repeat); end
    for (int k = 1; k <= 5; k++) begin
      tick();
      tests_run++;
      if ((btn_level | btn_rise) !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_wait pre k=%0d got level=%b rise=%b exp 0", k, btn_level, btn_rise); end
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests_run++;
    if ((btn_level | btn_rise | btn_fall) !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_wait outputs got l=%b r=%b f=%b exp 0", btn_level, btn_rise, btn_fall); end
    for (int k = 1; k <= 10; k++) begin
      tick();
      exp_level = (k >= 7);
      exp_rise  = (k == 7);
      tests_run++;
      if (btn_level !== exp_level) begin tests_failed++; $display("[TB] FAIL rst_wait level k=%0d got %b exp %b", k, btn_level, exp_level); end
      tests_run++;
      if (btn_rise !== exp_rise) begin tests_failed++; $display("[TB] FAIL rst_wait rise k=%0d got %b exp %b", k, btn_rise, exp_rise); end
      tests_run++;
      if (btn_fall !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_wait fall k=%0d got %b exp 0", k, btn_fall); end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    btn          = 1'b0;
    test_reset();
    test_glitch();
    test_clean_press();
    test_repeat();
    test_release();
    test_bounce();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
